fetch_prefetch: RTL and testbench

//  Parametrised fetch stage with an in-order prefetch queue between PC generation and decode.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_prefetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_prefetch.sv | 122 ++++++++++++
 tb/tb_fetch_prefetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the prefetching fetch stage
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Callers truncate the result back to their own address width.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc, input int unsigned inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// rtl/fetch_prefetch_if.sv - memory request/response and decode handshake bundle
interface fetch_prefetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_next;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order prefetch queue holding {instr, pc} entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - credit-limited prefetching fetch stage; FETCH_PERF_EN adds perf counters
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 16,
  parameter int                 DEPTH    = 4,
  parameter int unsigned        PC_INC   = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input logic              clk,
  input logic              rst,
  fetch_prefetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
`endif
);

  localparam int               CNT_W      = ptr_w(DEPTH) + 1;
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W+1)'(DEPTH);

  fetch_state_t             state_q, state_n;
  logic                     active_q;
  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_n, resp_pc_q, resp_pc_n;
  logic [CNT_W-1:0]         outstanding_q, outstanding_n, drop_cnt_q, drop_cnt_n;
  logic [CNT_W-1:0]         occupancy;
  logic [CNT_W:0]           credit_used;
  logic                     req, grant, push, pop, fifo_full, fifo_empty;
  logic [DATA_W+ADDR_W-1:0] head;

  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding_q};
  // Responses racing a redirect belong to the old stream and are never queued.
  assign push = bus.imem_rvalid && (state_q == RUN) && !bus.redirect;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    state_n       = state_q;
    fetch_pc_n    = fetch_pc_q;
    resp_pc_n     = resp_pc_q;
    outstanding_n = outstanding_q;
    drop_cnt_n    = drop_cnt_q;
    req           = 1'b0;
    case (state_q)
      RUN:   req = active_q && (credit_used < CREDIT_MAX);
      FLUSH: begin
        if (drop_cnt_q == '0) state_n = RUN;
        else if (bus.imem_rvalid) drop_cnt_n = drop_cnt_q - CNT_W'(1);
      end
      default: state_n = RUN;
    endcase
    grant = req && bus.imem_gnt;
    if (grant) fetch_pc_n = ADDR_W'(pc_inc(32'(fetch_pc_q), PC_INC));
    if (grant && !bus.imem_rvalid)      outstanding_n = outstanding_q + CNT_W'(1);
    else if (!grant && bus.imem_rvalid) outstanding_n = outstanding_q - CNT_W'(1);
    if (push) resp_pc_n = ADDR_W'(pc_inc(32'(resp_pc_q), PC_INC));
    if (bus.redirect) begin
      fetch_pc_n = bus.redirect_pc;
      resp_pc_n  = bus.redirect_pc;
      drop_cnt_n = outstanding_n;
      state_n    = (outstanding_n != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      active_q      <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_n;
      active_q      <= 1'b1;
      fetch_pc_q    <= fetch_pc_n;
      resp_pc_q     <= resp_pc_n;
      outstanding_q <= outstanding_n;
      drop_cnt_q    <= drop_cnt_n;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.imem_rdata, resp_pc_q}),
    .pop       (pop),
    .flush     (bus.redirect),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = active_q ? fetch_pc_q : '0;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_instr   = fifo_empty ? '0 : head[ADDR_W +: DATA_W];
  assign bus.out_pc      = fifo_empty ? '0 : head[ADDR_W-1:0];
  assign bus.out_pc_next = fifo_empty ? '0 : ADDR_W'(pc_inc(32'(head[ADDR_W-1:0]), PC_INC));

  a_credit: assert property (@(posedge clk) disable iff (!rst)
    (credit_used <= CREDIT_MAX) && !(push && fifo_full && !pop));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (bus.out_ready && !bus.out_valid && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - directed self-checking bench for fetch_prefetch
module tb_fetch_prefetch;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } rd_t;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   mem_lat = 1;
  int   neg_cnt = 0;
  int   grant_cnt = 0;
  rd_t  rq[$];
  rd_t  new_rd;

  fetch_prefetch_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  fetch_prefetch_if #(.DATA_W(16), .ADDR_W(16)) w_bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  fetch_prefetch #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  fetch_prefetch #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'hFFFE)
  ) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (w_bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (w_perf_fetched),
    .perf_stall   (w_perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: grants whenever requested, answers in order mem_lat cycles after the grant.
  always @(negedge clk) begin
    neg_cnt++;
    if (!rst) begin
      rq.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end else begin
      if (rq.size() > 0 && rq[0].due <= neg_cnt) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rq[0].addr ^ 16'h5A5A;
        void'(rq.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
      end
      if (bus.imem_req && bus.imem_gnt) begin
        new_rd.addr = bus.imem_addr;
        new_rd.due  = neg_cnt + mem_lat;
        rq.push_back(new_rd);
        grant_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_gnt = 1'b1;
    bus.out_ready = 1'b1;
    w_bus.redirect = 1'b0;
    w_bus.redirect_pc = '0;
    w_bus.imem_gnt = 1'b1;
    w_bus.imem_rvalid = 1'b0;
    w_bus.imem_rdata = '0;
    w_bus.out_ready = 1'b0;

    repeat (3) tick();
    check("rst_req",     32'(bus.imem_req),    32'd0);
    check("rst_valid",   32'(bus.out_valid),   32'd0);
    check("rst_addr",    32'(bus.imem_addr),   32'd0);
    check("rst_instr",   32'(bus.out_instr),   32'd0);
    check("rst_pc",      32'(bus.out_pc),      32'd0);
    check("rst_pc_next", 32'(bus.out_pc_next), 32'd0);
    check("rst_w_req",   32'(w_bus.imem_req),  32'd0);

    // 1: streaming with 1-cycle memory; 5: wrap instance address sequence
    rst = 1'b1;
    tick();
    check("t1_req",    32'(bus.imem_req),    32'd1);
    check("t1_addr0",  32'(bus.imem_addr),   32'h0000);
    check("t5_addr0",  32'(w_bus.imem_addr), 32'hFFFE);
    tick();
    check("t1_addr1",  32'(bus.imem_addr),   32'h0002);
    check("t5_addr1",  32'(w_bus.imem_addr), 32'h0000);
    check("t1_nvalid", 32'(bus.out_valid),   32'd0);
    tick();
    check("t1_valid",   32'(bus.out_valid),   32'd1);
    check("t1_pc0",     32'(bus.out_pc),      32'h0000);
    check("t1_pcnext0", 32'(bus.out_pc_next), 32'h0002);
    check("t1_instr0",  32'(bus.out_instr),   32'h5A5A);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t1_pc",     32'(bus.out_pc),      32'(2 * k));
      check("t1_pcnext", 32'(bus.out_pc_next), 32'(2 * k + 2));
      check("t1_instr",  32'(bus.out_instr),   32'(16'(2 * k) ^ 16'h5A5A));
    end

    // 2: decode stalled after a redirect to 0x0040 -> exactly 4 grants, then held in order
    bus.out_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0040;
    tick();
    bus.redirect = 1'b0;
    grant_cnt = 0;
    check("t2_flush_valid", 32'(bus.out_valid), 32'd0);
    repeat (12) tick();
    check("t2_grants", 32'(grant_cnt),       32'd4);
    check("t2_req",    32'(bus.imem_req),    32'd0);
    check("t2_valid",  32'(bus.out_valid),   32'd1);
    check("t2_pc0",    32'(bus.out_pc),      32'h0040);
    check("t2_instr0", 32'(bus.out_instr),   32'h5A1A);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t2_pc", 32'(bus.out_pc), 32'(16'h0040 + 16'(2 * k)));
    end

    // 3: redirect with reads in flight at 3-cycle latency
    mem_lat = 3;
    repeat (10) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    check("t3_valid_off", 32'(bus.out_valid), 32'd0);
    check("t3_req_off",   32'(bus.imem_req),  32'd0);
    wait_valid(30, "t3_wait");
    check("t3_pc",     32'(bus.out_pc),      32'h0100);
    check("t3_pcnext", 32'(bus.out_pc_next), 32'h0102);
    check("t3_instr",  32'(bus.out_instr),   32'h5B5A);

    // 4: redirect with nothing outstanding (queue full, decode stalled)
    bus.out_ready = 1'b0;
    repeat (15) tick();
    check("t4_full_req", 32'(bus.imem_req), 32'd0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0200;
    tick();
    bus.redirect = 1'b0;
    check("t4_req",   32'(bus.imem_req),  32'd1);
    check("t4_addr",  32'(bus.imem_addr), 32'h0200);
    check("t4_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    wait_valid(20, "t4_wait");
    check("t4_pc", 32'(bus.out_pc), 32'h0200);

    // 6: reset in the middle of a burst
    mem_lat = 1;
    repeat (6) tick();
    check("t6_stream", 32'(bus.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_req",   32'(bus.imem_req),  32'd0);
    check("t6_pc",    32'(bus.out_pc),    32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("t6_req_on", 32'(bus.imem_req),  32'd1);
    check("t6_addr",   32'(bus.imem_addr), 32'h0000);
    wait_valid(10, "t6_wait");
    check("t6_pc0",    32'(bus.out_pc),    32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
